afe_flag_fifo: RTL
==================

AFE_FLAG_FIFO -- requirements
Module: afe_flag_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 8: FIFO entries; power of two, minimum 2.
REQ-002 SHALL have parameter DATA_WIDTH, default 32: width of a flag word.
REQ-003 SHALL have parameter LVL_WIDTH, default $clog2(DEPTH)+1: width of the level counter.
REQ-004 SHALL have port clk_i  in  1  sole clock; all logic on its rising edge.
REQ-005 SHALL have port rst_ni  in  1  reset; synchronous, active-low.
REQ-006 SHALL have port test_mode_i  in  1  test mode; no functional effect.
REQ-007 SHALL have port clr_i  in  1  synchronous FIFO flush, from the register interface.
REQ-008 SHALL have port drop_mode_i  in  1  full-FIFO policy: 0 = backpressure, 1 = drop the incoming word.
REQ-009 SHALL have port in_valid_i  in  1  flag word valid; driven by the flag generator's flag_valid_o.
REQ-010 SHALL have port in_ready_o  out  1  FIFO accepts the word; drives the flag generator's flag_ready_i.
REQ-011 SHALL have port in_data_i  in  DATA_WIDTH  flag word (chid, flags, write pointer).
REQ-012 SHALL have port pop_i  in  1  single-cycle pop strobe from a register-interface read.
REQ-013 SHALL have port out_valid_o  out  1  FIFO not empty.
REQ-014 SHALL have port out_data_o  out  DATA_WIDTH  head entry; '0 when empty.
REQ-015 SHALL have port level_o  out  LVL_WIDTH  current occupancy.
REQ-016 SHALL have port thresh_i  in  LVL_WIDTH  event threshold; 0 disables the event.
REQ-017 SHALL have port event_o  out  1  one-cycle pulse on an upward threshold crossing.
REQ-018 SHALL have port ovflw_o  out  1  sticky flag: a word was dropped.
REQ-019 SHALL have port ovflw_clr_i  in  1  clears ovflw_o.

Function
REQ-020 SHALL accept a push when in_valid_i && in_ready_o and write in_data_i at the write pointer.
REQ-021 SHALL drive in_ready_o = ~full when drop_mode_i=0, and 1 when drop_mode_i=1; in_ready_o has no combinational path from pop_i.
REQ-022 SHALL, when full with drop_mode_i=1, discard an accepted word, leave contents and level unchanged, and set ovflw_o on the next cycle.
REQ-023 SHALL pop the head on pop_i && out_valid_o; pop_i while empty is ignored with no state change.
REQ-024 SHALL process a simultaneous push and pop in one cycle with level unchanged; when full with drop_mode_i=1, the pop frees a slot, so the word is stored, not dropped.
REQ-025 SHALL make a word pushed into an empty FIFO visible on out_valid_o and out_data_o one cycle after acceptance; there is no fall-through.
REQ-026 SHALL wrap read and write pointers modulo DEPTH; full = (level == DEPTH), empty = (level == 0).
REQ-027 SHALL register level_o, which equals the number of stored entries; range 0..DEPTH.
REQ-028 SHALL pulse event_o, registered, in the cycle after level goes from below thresh_i to at least thresh_i, when thresh_i != 0; no re-trigger until level falls below thresh_i again.
REQ-029 SHALL, on clr_i, empty the FIFO next cycle (pointers 0, level 0), suppress event_o, and ignore any same-cycle push or pop; ovflw_o is unaffected.
REQ-030 SHALL give ovflw_clr_i priority over a same-cycle set of ovflw_o... no: a same-cycle drop SHALL win, leaving ovflw_o at 1.
REQ-031 SHALL treat thresh_i > DEPTH as never crossing.

Reset
REQ-032 SHALL, when rst_ni=0 at a clock edge, apply: pointers 0, level_o 0, out_valid_o 0, out_data_o '0, event_o 0, ovflw_o 0.
REQ-033 SHALL drive in_ready_o to 1 during reset and after it (empty FIFO); storage array contents are not reset.
REQ-034 SHALL, on reset mid-operation, discard all stored words; a word presented in the reset cycle is not accepted.

Structure
REQ-035 SHALL place the flag-word field offsets (chid at 24, flags at 16, write pointer at 0) and the default DEPTH in the shared AFE package, for reuse by the register interface.
REQ-036 SHALL keep the storage in one sub-module, afe_flag_fifo_mem: DEPTH x DATA_WIDTH registers with one write port and an asynchronous read port; all control stays in afe_flag_fifo.

Verification
REQ-037 SHALL cover: 8 pushes with drop_mode_i=0 -> level_o=8, in_ready_o=0; the 9th word is held by the producer and accepted the cycle after one pop; FIFO order preserved.
REQ-038 SHALL cover: full, drop_mode_i=1, push 32'hDEAD0001 -> word absent from all 8 pops, ovflw_o=1 until ovflw_clr_i.
REQ-039 SHALL cover: thresh_i=4, push 4 words -> event_o exactly once, one cycle after the 4th push; pop 1, push 1 -> second pulse.
REQ-040 SHALL cover: level 3, simultaneous push and pop for 20 cycles -> level_o stays 3, pointers wrap, data in order.
REQ-041 SHALL cover: level 5, clr_i asserted with a same-cycle push -> level_o=0 and out_valid_o=0 next cycle, pushed word lost.
REQ-042 SHALL cover: rst_ni=0 for one cycle at level 6 -> all outputs at reset values on the next cycle; pop_i on empty -> no change.

Source files
------------

// File: rtl/afe_flag_fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : afe_flag_fifo_pkg
// Description : Shared AFE definitions for the flag-word FIFO and the register
//               interface that reads it. Holds the default FIFO depth, the
//               flag-word field layout, and a helper that packs a flag word.
// Revision    : 1.0 - initial release
// ============================================================================
package afe_flag_fifo_pkg;

  // Default FIFO geometry
  localparam int AFE_FLAG_DEPTH      = 8;
  localparam int AFE_FLAG_DATA_WIDTH = 32;

  // Flag-word field layout: {chid[31:24], flags[23:16], wptr[15:0]}
  localparam int AFE_FLAG_CHID_LSB   = 24;
  localparam int AFE_FLAG_CHID_W     = 8;
  localparam int AFE_FLAG_FLAGS_LSB  = 16;
  localparam int AFE_FLAG_FLAGS_W    = 8;
  localparam int AFE_FLAG_WPTR_LSB   = 0;
  localparam int AFE_FLAG_WPTR_W     = 16;

  // Pack the three fields into one flag word.
  function automatic logic [AFE_FLAG_DATA_WIDTH-1:0] afe_flag_word(
    input logic [AFE_FLAG_CHID_W-1:0]  chid,
    input logic [AFE_FLAG_FLAGS_W-1:0] flags,
    input logic [AFE_FLAG_WPTR_W-1:0]  wptr
  );
    logic [AFE_FLAG_DATA_WIDTH-1:0] w;
    w = '0;
    w[AFE_FLAG_CHID_LSB  +: AFE_FLAG_CHID_W]  = chid;
    w[AFE_FLAG_FLAGS_LSB +: AFE_FLAG_FLAGS_W] = flags;
    w[AFE_FLAG_WPTR_LSB  +: AFE_FLAG_WPTR_W]  = wptr;
    return w;
  endfunction

endpackage : afe_flag_fifo_pkg
`default_nettype wire

// File: rtl/afe_flag_fifo_mem.sv
`default_nettype none
// ============================================================================
// Module      : afe_flag_fifo_mem
// Description : Storage array for the flag FIFO. DEPTH x DATA_WIDTH registers,
//               one synchronous write port, one asynchronous read port.
//               Contents are deliberately not reset.
// Ports       : clk_i   - clock
//               we_i    - write enable
//               waddr_i - write address
//               wdata_i - write data
//               raddr_i - read address
//               rdata_o - read data (combinational)
// Revision    : 1.0 - initial release
// ============================================================================
module afe_flag_fifo_mem #(
  parameter int DEPTH      = 8,
  parameter int DATA_WIDTH = 32,
  parameter int AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [AW-1:0]         waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]         raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule : afe_flag_fifo_mem
`default_nettype wire

// File: rtl/afe_flag_fifo.sv
`default_nettype none
// ============================================================================
// Module      : afe_flag_fifo
// Description : Flag-word FIFO between the flag generator and the register
//               interface. Backpressure or drop-on-full policy, registered
//               occupancy, threshold crossing event, sticky overflow flag.
// Ports       : clk_i, rst_ni       - clock, synchronous active-low reset
//               test_mode_i         - test mode (no functional effect)
//               clr_i               - synchronous flush
//               drop_mode_i         - 0: backpressure when full, 1: drop
//               in_valid_i/in_ready_o/in_data_i - push handshake
//               pop_i               - pop strobe
//               out_valid_o/out_data_o - head entry ('0 when empty)
//               level_o             - occupancy 0..DEPTH
//               thresh_i / event_o  - threshold and crossing pulse
//               ovflw_o / ovflw_clr_i - sticky drop flag and its clear
// Revision    : 1.0 - initial release
// ============================================================================
module afe_flag_fifo
  import afe_flag_fifo_pkg::*;
#(
  parameter int DEPTH      = AFE_FLAG_DEPTH,
  parameter int DATA_WIDTH = AFE_FLAG_DATA_WIDTH,
  parameter int LVL_WIDTH  = $clog2(DEPTH) + 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  test_mode_i,
  input  logic                  clr_i,
  input  logic                  drop_mode_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [DATA_WIDTH-1:0] in_data_i,
  input  logic                  pop_i,
  output logic                  out_valid_o,
  output logic [DATA_WIDTH-1:0] out_data_o,
  output logic [LVL_WIDTH-1:0]  level_o,
  input  logic [LVL_WIDTH-1:0]  thresh_i,
  output logic                  event_o,
  output logic                  ovflw_o,
  input  logic                  ovflw_clr_i
);

  localparam int                   AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [LVL_WIDTH-1:0] DEPTH_LVL = LVL_WIDTH'(DEPTH);

  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [LVL_WIDTH-1:0]  level_q,  level_d;
  logic                  event_q,  event_d;
  logic                  ovflw_q,  ovflw_d;

  logic                  w_full;
  logic                  w_empty;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_store;
  logic                  w_drop;
  logic                  w_thr_en;
  logic [DATA_WIDTH-1:0] w_head;

  // Test mode has no functional effect in this block.
  logic unused_test_mode;
  assign unused_test_mode = test_mode_i;

  assign w_full  = (level_q == DEPTH_LVL);
  assign w_empty = (level_q == '0);

  // Ready depends only on registered state and static inputs, never on pop_i.
  // Held high while in reset so the producer sees an empty FIFO.
  assign in_ready_o = !rst_ni || drop_mode_i || !w_full;

  // A flush swallows any same-cycle push or pop.
  assign w_push  = in_valid_i && in_ready_o && !clr_i;
  assign w_pop   = pop_i && !w_empty && !clr_i;
  // When full, a same-cycle pop frees the slot so the word is kept.
  assign w_store = w_push && (!w_full || w_pop);
  assign w_drop  = w_push && w_full && !w_pop;

  // Zero disables the event; a threshold beyond DEPTH can never be reached.
  assign w_thr_en = (thresh_i != '0) && (thresh_i <= DEPTH_LVL);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    event_d  = 1'b0;
    ovflw_d  = ovflw_q;

    if (clr_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (w_store) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (w_pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      unique case ({w_store, w_pop})
        2'b10:   level_d = level_q + LVL_WIDTH'(1);
        2'b01:   level_d = level_q - LVL_WIDTH'(1);
        default: level_d = level_q;
      endcase
      // Edge detect on the level itself: fires once per upward crossing.
      event_d = w_thr_en && (level_q < thresh_i) && (level_d >= thresh_i);
    end

    // A drop in the same cycle as the clear wins.
    if (w_drop) begin
      ovflw_d = 1'b1;
    end else if (ovflw_clr_i) begin
      ovflw_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      event_q  <= 1'b0;
      ovflw_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      event_q  <= event_d;
      ovflw_q  <= ovflw_d;
    end
  end

  afe_flag_fifo_mem #(
    .DEPTH      (DEPTH),
    .DATA_WIDTH (DATA_WIDTH),
    .AW         (AW)
  ) u_mem (
    .clk_i   (clk_i),
    .we_i    (w_store && rst_ni),
    .waddr_i (wr_ptr_q),
    .wdata_i (in_data_i),
    .raddr_i (rd_ptr_q),
    .rdata_o (w_head)
  );

  assign out_valid_o = !w_empty;
  assign out_data_o  = w_empty ? '0 : w_head;
  assign level_o     = level_q;
  assign event_o     = event_q;
  assign ovflw_o     = ovflw_q;

endmodule : afe_flag_fifo
`default_nettype wire
